// File: rtl/lsu_pkg.sv
// Shared types and helpers for the multi-cycle load/store unit:
// FSM states, access sizes, funct3 encodings and the legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RSP,
        ST_DONE
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W,
        SZ_D
    } lsu_size_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    function automatic lsu_size_e size_of(input logic [2:0] funct3);
        return lsu_size_e'(funct3[1:0]);
    endfunction

    // Covers both funct3 legality for the datapath width and natural alignment.
    function automatic logic access_legal(input logic       wen,
                                          input logic [2:0] funct3,
                                          input logic [2:0] addr_lo,
                                          input logic       is64);
        logic ok;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~addr_lo[0];
            F3_W:    ok = (addr_lo[1:0] == 2'b00);
            F3_D:    ok = is64 && (addr_lo == 3'b000);
            F3_BU:   ok = ~wen;
            F3_HU:   ok = ~wen && ~addr_lo[0];
            F3_WU:   ok = ~wen && is64 && (addr_lo[1:0] == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store data/strobe placement and load
// extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]                  size,
    input  logic                        sext,
    input  logic [$clog2(DATA_W/8)-1:0] offset,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [DATA_W-1:0]           raw,
    output logic [DATA_W-1:0]           st_wdata,
    output logic [DATA_W/8-1:0]         st_wstrb,
    output logic [DATA_W-1:0]           ld_data
);

    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0]  shifted;
    logic [7:0]         strb_base;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] w_s;

    always_comb begin
        shifted  = raw >> {offset, 3'b000};
        st_wdata = wdata << {offset, 3'b000};

        case (size)
            SZ_B:    strb_base = 8'h01;
            SZ_H:    strb_base = 8'h03;
            SZ_W:    strb_base = 8'h0F;
            default: strb_base = 8'hFF;
        endcase
        st_wstrb = strb_base[STRB_W-1:0] << offset;

        // Signed views let the width cast perform the sign extension.
        b_s = shifted[7:0];
        h_s = shifted[15:0];
        w_s = shifted[31:0];
        case (size)
            SZ_B:    ld_data = sext ? DATA_W'(b_s) : DATA_W'(shifted[7:0]);
            SZ_H:    ld_data = sext ? DATA_W'(h_s) : DATA_W'(shifted[15:0]);
            SZ_W:    ld_data = sext ? DATA_W'(w_s) : DATA_W'(shifted[31:0]);
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: accepts one operation, issues it on a
// valid/ready memory port and returns extended load data or a store ack.
module lsu_mc
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_wen,
    input  logic [2:0]          in_funct3,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_rdata,
    output logic                out_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_wen,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata
);

    localparam int   STRB_W = DATA_W / 8;
    localparam int   OFF_W  = $clog2(STRB_W);
    localparam logic IS64   = (DATA_W == 64);

    lsu_state_e        state;
    logic              wen_q;
    logic [2:0]        f3_q;
    logic [OFF_W-1:0]  off_q;

    logic              idle;
    logic              legal;
    logic [2:0]        al_f3;
    logic [OFF_W-1:0]  al_off;
    logic [DATA_W-1:0] al_wdata;
    logic [STRB_W-1:0] al_wstrb;
    logic [DATA_W-1:0] al_ld;

    // The aligner sees the live request while idle and the latched one afterwards.
    assign idle   = (state == ST_IDLE);
    assign al_f3  = idle ? in_funct3 : f3_q;
    assign al_off = idle ? in_addr[OFF_W-1:0] : off_q;
    assign legal  = access_legal(in_wen, in_funct3, in_addr[2:0], IS64);

    lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .size     (size_of(al_f3)),
        .sext     (~al_f3[2]),
        .offset   (al_off),
        .wdata    (in_wdata),
        .raw      (mem_rsp_rdata),
        .st_wdata (al_wdata),
        .st_wstrb (al_wstrb),
        .ld_data  (al_ld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            wen_q         <= 1'b0;
            f3_q          <= 3'b000;
            off_q         <= '0;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            out_err       <= 1'b0;
            out_rdata     <= '0;
            mem_req_valid <= 1'b0;
            mem_req_wen   <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        wen_q    <= in_wen;
                        f3_q     <= in_funct3;
                        off_q    <= in_addr[OFF_W-1:0];
                        in_ready <= 1'b0;
                        if (legal) begin
                            mem_req_valid <= 1'b1;
                            mem_req_wen   <= in_wen;
                            mem_req_addr  <= {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_req_wdata <= in_wen ? al_wdata : '0;
                            mem_req_wstrb <= in_wen ? al_wstrb : '0;
                            state         <= ST_REQ;
                        end else begin
                            out_err   <= 1'b1;
                            out_valid <= 1'b1;
                            out_rdata <= '0;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (mem_rsp_valid) begin
                        out_rdata <= wen_q ? '0 : al_ld;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_err   <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mc.sv
// Bench for lsu_mc: a 32-bit and a 64-bit instance driven one at a time,
// checked against a byte-arithmetic reference model.
module tb_lsu_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel64;
    logic        in_valid;
    logic        in_wen;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [63:0] in_wdata;
    logic        out_ready;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_rdata;

    logic        ir32, ov32, oe32, rv32, rw32;
    logic [31:0] rd32, ra32, wd32;
    logic [3:0]  st32;
    logic        ir64, ov64, oe64, rv64, rw64;
    logic [63:0] rd64, wd64;
    logic [31:0] ra64;
    logic [7:0]  st64;

    logic        o_in_ready, o_out_valid, o_out_err, o_req_valid, o_req_wen;
    logic [63:0] o_rdata, o_req_wdata;
    logic [31:0] o_req_addr;
    logic [7:0]  o_req_wstrb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_mc #(.DATA_W(32), .ADDR_W(32)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & ~sel64), .in_ready(ir32), .in_wen(in_wen),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata[31:0]),
        .out_valid(ov32), .out_ready(out_ready), .out_rdata(rd32), .out_err(oe32),
        .mem_req_valid(rv32), .mem_req_ready(mem_req_ready), .mem_req_wen(rw32),
        .mem_req_addr(ra32), .mem_req_wdata(wd32), .mem_req_wstrb(st32),
        .mem_rsp_valid(mem_rsp_valid & ~sel64), .mem_rsp_rdata(mem_rsp_rdata[31:0])
    );

    lsu_mc #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & sel64), .in_ready(ir64), .in_wen(in_wen),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .out_valid(ov64), .out_ready(out_ready), .out_rdata(rd64), .out_err(oe64),
        .mem_req_valid(rv64), .mem_req_ready(mem_req_ready), .mem_req_wen(rw64),
        .mem_req_addr(ra64), .mem_req_wdata(wd64), .mem_req_wstrb(st64),
        .mem_rsp_valid(mem_rsp_valid & sel64), .mem_rsp_rdata(mem_rsp_rdata)
    );

    assign o_in_ready  = sel64 ? ir64 : ir32;
    assign o_out_valid = sel64 ? ov64 : ov32;
    assign o_out_err   = sel64 ? oe64 : oe32;
    assign o_req_valid = sel64 ? rv64 : rv32;
    assign o_req_wen   = sel64 ? rw64 : rw32;
    assign o_rdata     = sel64 ? rd64 : {32'd0, rd32};
    assign o_req_wdata = sel64 ? wd64 : {32'd0, wd32};
    assign o_req_addr  = sel64 ? ra64 : ra32;
    assign o_req_wstrb = sel64 ? st64 : {4'd0, st32};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mask(input int bits);
        return (bits >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
    endfunction

    // Reference: byte counts and offsets straight from the access rules.
    function automatic void model(input int w, input logic wen, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [63:0] wd,
                                  input logic [63:0] raw, output logic err,
                                  output logic [31:0] raddr, output logic [63:0] rwd,
                                  output logic [7:0] rstrb, output logic [63:0] rd);
        int nb, bits, off;
        logic [63:0] v;
        nb   = 1 << f3[1:0];
        bits = 8 * nb;
        off  = int'(addr[2:0]) % (w / 8);
        err  = (f3 == 3'd7) || (nb == 8 && w == 32) || (f3 == 3'd6 && w == 32) ||
               (wen && f3[2]) || ((int'(addr[2:0]) % nb) != 0);
        raddr = addr - 32'(off);
        rwd   = wen ? (((wd & mask(w)) << (8 * off)) & mask(w)) : 64'd0;
        rstrb = wen ? 8'(mask(nb) << off) : 8'd0;
        v = ((raw & mask(w)) >> (8 * off)) & mask(bits);
        if (!f3[2] && v[bits-1]) v = v | ~mask(bits);
        rd = (wen || err) ? 64'd0 : (v & mask(w));
    endfunction

    task automatic chk_reset(input string p);
        chk({p, "_in_ready"}, o_in_ready, 1);
        chk({p, "_out_valid"}, o_out_valid, 0);
        chk({p, "_out_err"}, o_out_err, 0);
        chk({p, "_out_rdata"}, o_rdata, 0);
        chk({p, "_req_valid"}, o_req_valid, 0);
        chk({p, "_req_wen"}, o_req_wen, 0);
        chk({p, "_req_addr"}, o_req_addr, 0);
        chk({p, "_req_wdata"}, o_req_wdata, 0);
        chk({p, "_req_wstrb"}, o_req_wstrb, 0);
    endtask

    task automatic do_txn(input bit is64, input logic wen, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [63:0] wd,
                          input logic [63:0] raw, input int req_dly,
                          input int rsp_dly, input int out_dly);
        logic        e_err;
        logic [31:0] e_addr;
        logic [63:0] e_wd, e_rd;
        logic [7:0]  e_strb;
        model(is64 ? 64 : 32, wen, f3, addr, wd, raw, e_err, e_addr, e_wd, e_strb, e_rd);
        sel64 = is64;
        @(negedge clk);
        chk("idle_in_ready", o_in_ready, 1);
        in_valid = 1'b1; in_wen = wen; in_funct3 = f3; in_addr = addr; in_wdata = wd;
        @(negedge clk);
        in_valid = 1'b0;
        in_wdata = {$urandom, $urandom};
        chk("acc_in_ready", o_in_ready, 0);
        if (e_err) begin
            chk("err_out_valid", o_out_valid, 1);
            chk("err_out_err", o_out_err, 1);
            chk("err_rdata", o_rdata, 0);
            chk("err_req_valid", o_req_valid, 0);
        end else begin
            chk("req_valid", o_req_valid, 1);
            chk("req_wen", o_req_wen, wen);
            chk("req_addr", o_req_addr, e_addr);
            chk("req_wdata", o_req_wdata, e_wd);
            chk("req_wstrb", o_req_wstrb, e_strb);
            chk("req_out_valid", o_out_valid, 0);
            for (int i = 0; i < req_dly; i++) begin
                mem_rsp_valid = 1'($urandom_range(0, 1));
                mem_rsp_rdata = {$urandom, $urandom};
                @(negedge clk);
                chk("hold_req_valid", o_req_valid, 1);
                chk("hold_req_addr", o_req_addr, e_addr);
                chk("hold_req_wdata", o_req_wdata, e_wd);
                chk("hold_req_wstrb", o_req_wstrb, e_strb);
                chk("hold_out_valid", o_out_valid, 0);
            end
            mem_rsp_valid = 1'b0;
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            chk("rsp_req_valid", o_req_valid, 0);
            chk("rsp_out_valid", o_out_valid, 0);
            for (int i = 0; i < rsp_dly; i++) begin
                @(negedge clk);
                chk("wait_out_valid", o_out_valid, 0);
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = raw;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_rsp_rdata = {$urandom, $urandom};
            chk("done_out_valid", o_out_valid, 1);
            chk("done_out_err", o_out_err, 0);
            chk("done_rdata", o_rdata, e_rd);
        end
        for (int i = 0; i < out_dly; i++) begin
            @(negedge clk);
            chk("stall_out_valid", o_out_valid, 1);
            chk("stall_rdata", o_rdata, e_rd);
            chk("stall_out_err", o_out_err, e_err);
            chk("stall_in_ready", o_in_ready, 0);
            chk("stall_req_valid", o_req_valid, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ack_out_valid", o_out_valid, 0);
        chk("ack_in_ready", o_in_ready, 1);
    endtask

    initial begin
        rst = 1'b1; sel64 = 1'b0; in_valid = 1'b0; in_wen = 1'b0; in_funct3 = 3'd0;
        in_addr = 32'd0; in_wdata = 64'd0; out_ready = 1'b0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_rdata = 64'd0;
        repeat (2) @(negedge clk);
        chk_reset("rst32");
        sel64 = 1'b1;
        #1;
        chk_reset("rst64");
        @(negedge clk);
        rst = 1'b0;

        // LB sign-extends 0x80 from the top lane
        do_txn(0, 1'b0, 3'b000, 32'h8000_0003, 64'd0, 64'h0000_0000_80AB_CDEF, 0, 0, 0);
        // SH into upper halfword
        do_txn(0, 1'b1, 3'b001, 32'h8000_0002, 64'h0000_0000_0000_1234, 64'd0, 0, 0, 0);
        // misaligned LW
        do_txn(0, 1'b0, 3'b010, 32'h8000_0001, 64'd0, 64'd0, 0, 0, 0);
        // illegal on 32-bit: LD, LWU, funct3 111, unsigned store
        do_txn(0, 1'b0, 3'b011, 32'h8000_0000, 64'd0, 64'd0, 0, 0, 1);
        do_txn(0, 1'b0, 3'b110, 32'h8000_0000, 64'd0, 64'd0, 0, 0, 0);
        do_txn(0, 1'b0, 3'b111, 32'h8000_0000, 64'd0, 64'd0, 0, 0, 0);
        do_txn(0, 1'b1, 3'b100, 32'h8000_0000, 64'd0, 64'd0, 0, 0, 0);
        // 64-bit LWU / LW from upper word
        do_txn(1, 1'b0, 3'b110, 32'h8000_0004, 64'd0, 64'hF000_0000_0000_0001, 0, 0, 0);
        do_txn(1, 1'b0, 3'b010, 32'h8000_0004, 64'd0, 64'hF000_0000_0000_0001, 0, 0, 0);
        do_txn(1, 1'b0, 3'b011, 32'h8000_0008, 64'd0, 64'h8123_4567_89AB_CDEF, 0, 0, 0);
        do_txn(1, 1'b1, 3'b011, 32'h8000_0008, 64'h1122_3344_5566_7788, 64'd0, 0, 0, 0);
        // back-pressure on both sides
        do_txn(0, 1'b0, 3'b101, 32'h8000_0002, 64'd0, 64'h0000_0000_9876_5432, 4, 1, 3);
        do_txn(1, 1'b1, 3'b000, 32'h8000_0005, 64'h0000_0000_0000_00A5, 64'd0, 4, 2, 3);

        // reset while waiting for the response
        sel64 = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_wen = 1'b0; in_funct3 = 3'b000; in_addr = 32'h8000_0001;
        @(negedge clk);
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_reset("midrst");
        @(negedge clk);
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("late_rsp_out_valid", o_out_valid, 0);
        chk("late_rsp_in_ready", o_in_ready, 1);
        do_txn(0, 1'b0, 3'b100, 32'h8000_0002, 64'd0, 64'h0000_0000_00C3_0000, 0, 0, 0);

        for (int i = 0; i < 80; i++) begin
            do_txn(i[0], 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'h8000_0000 + 32'($urandom_range(0, 255)),
                   {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
